turn_controller: RTL and testbench

Sequencing controller for the Battleship shot datapath. It alternates turns between two players and accepts a fire pulse only from the player whose turn it is. It loads that player's target coordinate into the shared shot-coordinate `Register` through its `en`/`D` pins, waits for the board lookup, and then scores the result. It sits between the two player input front-ends (debounced fire pulses plus coordinate switches) and the shared shot register and board memory.

---
 rtl/turn_controller.sv | 195 +++++++++++++++++++
 tb/tb_turn_controller.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/turn_controller.sv
`default_nettype none
// ============================================================================
// Module      : turn_controller
// Description : Turn sequencer for the Battleship shot datapath. Alternates
//               turns between two players and accepts a fire pulse only from
//               the active player. It loads that player's coordinate into the
//               shared shot register, waits LOOKUP_CYC cycles for the board
//               lookup, then scores the shot as a hit, a miss or a duplicate.
// Ports       : clk, clr (async, active-low)  - clock / reset
//               new_game                      - restart pulse, top priority
//               fire0/fire1, coord0/coord1    - player fire pulses + targets
//               reg_en, reg_d                 - shared shot register load
//               lkp_hit, lkp_dup              - board lookup result
//               turn, busy                    - active player / shot in flight
//               hit_pulse/miss_pulse/dup_pulse- one-cycle result strobes
//               score0, score1                - hits landed per player
//               game_over, winner             - end-of-game status
// Revision    : 1.0 - initial release
// ============================================================================
module turn_controller #(
    parameter int COORD_W    = 6,
    parameter int HIT_CELLS  = 17,
    parameter int LOOKUP_CYC = 2,
    parameter int SW         = $clog2(HIT_CELLS + 1)
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               new_game,
    input  logic               fire0,
    input  logic               fire1,
    input  logic [COORD_W-1:0] coord0,
    input  logic [COORD_W-1:0] coord1,
    output logic               reg_en,
    output logic [COORD_W-1:0] reg_d,
    input  logic               lkp_hit,
    input  logic               lkp_dup,
    output logic               turn,
    output logic               busy,
    output logic               hit_pulse,
    output logic               miss_pulse,
    output logic               dup_pulse,
    output logic [SW-1:0]      score0,
    output logic [SW-1:0]      score1,
    output logic               game_over,
    output logic               winner
);

    // Counter only has to hold LOOKUP_CYC-1; keep at least one bit.
    localparam int CW = (LOOKUP_CYC > 1) ? $clog2(LOOKUP_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_RESULT = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t          state_q,  state_d;
    logic            turn_q,   turn_d;
    logic            winner_q, winner_d;
    logic [SW-1:0]   score0_q, score0_d;
    logic [SW-1:0]   score1_q, score1_d;
    logic [CW-1:0]   cnt_q,    cnt_d;
    logic            hit_q,    hit_d;
    logic            dup_q,    dup_d;

    logic               fire_t;
    logic [COORD_W-1:0] coord_t;
    logic [SW-1:0]      score_cur;
    logic [SW-1:0]      score_inc;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q  <= S_IDLE;
            turn_q   <= 1'b0;
            winner_q <= 1'b0;
            score0_q <= '0;
            score1_q <= '0;
            cnt_q    <= '0;
            hit_q    <= 1'b0;
            dup_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            turn_q   <= turn_d;
            winner_q <= winner_d;
            score0_q <= score0_d;
            score1_q <= score1_d;
            cnt_q    <= cnt_d;
            hit_q    <= hit_d;
            dup_q    <= dup_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        fire_t    = turn_q ? fire1 : fire0;
        coord_t   = turn_q ? coord1 : coord0;
        score_cur = turn_q ? score1_q : score0_q;
        score_inc = score_cur + SW'(1);

        state_d  = state_q;
        turn_d   = turn_q;
        winner_d = winner_q;
        score0_d = score0_q;
        score1_d = score1_q;
        cnt_d    = cnt_q;
        hit_d    = hit_q;
        dup_d    = dup_q;

        case (state_q)
            S_IDLE: begin
                if (fire_t) begin
                    state_d = S_LOOKUP;
                    cnt_d   = CW'(LOOKUP_CYC - 1);
                end
            end
            S_LOOKUP: begin
                if (cnt_q == '0) begin
                    hit_d   = lkp_hit;
                    dup_d   = lkp_dup;
                    state_d = S_RESULT;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RESULT: begin
                // Duplicate wins over hit: the same player simply re-fires.
                if (dup_q) begin
                    state_d = S_IDLE;
                end else if (hit_q) begin
                    if (turn_q) score1_d = score_inc;
                    else        score0_d = score_inc;
                    if (score_inc == SW'(HIT_CELLS)) begin
                        winner_d = turn_q;
                        state_d  = S_DONE;
                    end else begin
                        turn_d  = ~turn_q;
                        state_d = S_IDLE;
                    end
                end else begin
                    turn_d  = ~turn_q;
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Restart overrides any fire or result resolving this cycle.
        if (new_game) begin
            state_d  = S_IDLE;
            turn_d   = 1'b0;
            winner_d = 1'b0;
            score0_d = '0;
            score1_d = '0;
            cnt_d    = '0;
            hit_d    = 1'b0;
            dup_d    = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic in_result;

    always_comb begin
        // Strobes are suppressed when new_game discards the result.
        in_result  = (state_q == S_RESULT) && !new_game;
        reg_d      = coord_t;
        // clr gating keeps the load enable quiet while reset is held, since
        // the flops already report IDLE then.
        reg_en     = (state_q == S_IDLE) && fire_t && !new_game && clr;
        busy       = (state_q == S_LOOKUP) || (state_q == S_RESULT);
        dup_pulse  = in_result && dup_q;
        hit_pulse  = in_result && !dup_q && hit_q;
        miss_pulse = in_result && !dup_q && !hit_q;
        game_over  = (state_q == S_DONE);
        turn       = turn_q;
        winner     = winner_q;
        score0     = score0_q;
        score1     = score1_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_turn_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_turn_controller
// Description : Self-checking bench for turn_controller (HIT_CELLS=3,
//               LOOKUP_CYC=2). A cycle-by-cycle vector table walks through
//               gating, miss, duplicate, win, DONE and new_game cases; a
//               hand-written sequence covers asynchronous reset mid-lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_turn_controller;

    localparam int COORD_W    = 6;
    localparam int HIT_CELLS  = 3;
    localparam int LOOKUP_CYC = 2;
    localparam int SW         = $clog2(HIT_CELLS + 1);
    localparam int OW         = 1 + COORD_W + 5 + 2 * SW + 2;

    logic               clk;
    logic               clr;
    logic               new_game;
    logic               fire0, fire1;
    logic [COORD_W-1:0] coord0, coord1;
    logic               reg_en;
    logic [COORD_W-1:0] reg_d;
    logic               lkp_hit, lkp_dup;
    logic               turn, busy;
    logic               hit_pulse, miss_pulse, dup_pulse;
    logic [SW-1:0]      score0, score1;
    logic               game_over, winner;

    int total;
    int bad;

    turn_controller #(
        .COORD_W   (COORD_W),
        .HIT_CELLS (HIT_CELLS),
        .LOOKUP_CYC(LOOKUP_CYC)
    ) u_dut (
        .clk       (clk),
        .clr       (clr),
        .new_game  (new_game),
        .fire0     (fire0),
        .fire1     (fire1),
        .coord0    (coord0),
        .coord1    (coord1),
        .reg_en    (reg_en),
        .reg_d     (reg_d),
        .lkp_hit   (lkp_hit),
        .lkp_dup   (lkp_dup),
        .turn      (turn),
        .busy      (busy),
        .hit_pulse (hit_pulse),
        .miss_pulse(miss_pulse),
        .dup_pulse (dup_pulse),
        .score0    (score0),
        .score1    (score1),
        .game_over (game_over),
        .winner    (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic               ng, f0, f1;
        logic [COORD_W-1:0] c0, c1;
        logic               h, d;
        logic [OW-1:0]      exp;
    } vec_t;

    vec_t vq[$];

    // Expected-output packing order:
    // {reg_en, reg_d, turn, busy, hit, miss, dup, score0, score1, game_over, winner}
    function automatic vec_t mk(input logic ng, f0, f1,
                                input logic [COORD_W-1:0] c0, c1,
                                input logic h, d,
                                input logic en, input logic [COORD_W-1:0] rd,
                                input logic t, b, hp, mp, dp,
                                input int s0, s1,
                                input logic go, w);
        vec_t v;
        v.ng = ng; v.f0 = f0; v.f1 = f1; v.c0 = c0; v.c1 = c1; v.h = h; v.d = d;
        v.exp = {en, rd, t, b, hp, mp, dp, SW'(s0), SW'(s1), go, w};
        return v;
    endfunction

    function automatic logic [OW-1:0] outs();
        return {reg_en, reg_d, turn, busy, hit_pulse, miss_pulse, dup_pulse,
                score0, score1, game_over, winner};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clr = 1'b0; new_game = 1'b0; fire0 = 1'b1; fire1 = 1'b0;
        coord0 = 6'o23; coord1 = 6'o45; lkp_hit = 1'b0; lkp_dup = 1'b0;

        //          ng f0 f1 c0     c1     h  d   en rd     t  b  hp mp dp s0 s1 go w
        vq.push_back(mk(0, 0, 0, 6'o23, 6'o45, 0, 0,  0, 6'o23, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // c0 idle
        vq.push_back(mk(0, 0, 1, 6'o23, 6'o45, 0, 0,  0, 6'o23, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // c1 wrong player
        vq.push_back(mk(0, 1, 0, 6'o23, 6'o45, 0, 0,  1, 6'o23, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // c2 fire0
        vq.push_back(mk(0, 0, 0, 6'o23, 6'o45, 1, 0,  0, 6'o23, 0, 1, 0, 0, 0, 0, 0, 0, 0)); // c3 lookup (hit ignored)
        vq.push_back(mk(0, 0, 0, 6'o23, 6'o45, 0, 0,  0, 6'o23, 0, 1, 0, 0, 0, 0, 0, 0, 0)); // c4 last lookup, miss
        vq.push_back(mk(0, 0, 0, 6'o23, 6'o45, 0, 0,  0, 6'o23, 0, 1, 0, 1, 0, 0, 0, 0, 0)); // c5 miss strobe
        vq.push_back(mk(0, 0, 1, 6'o23, 6'o45, 0, 0,  1, 6'o45, 1, 0, 0, 0, 0, 0, 0, 0, 0)); // c6 p1 fires
        vq.push_back(mk(0, 0, 1, 6'o23, 6'o45, 0, 0,  0, 6'o45, 1, 1, 0, 0, 0, 0, 0, 0, 0)); // c7 fire while busy
        vq.push_back(mk(0, 0, 0, 6'o23, 6'o45, 1, 1,  0, 6'o45, 1, 1, 0, 0, 0, 0, 0, 0, 0)); // c8 dup+hit
        vq.push_back(mk(0, 0, 0, 6'o23, 6'o45, 0, 0,  0, 6'o45, 1, 1, 0, 0, 1, 0, 0, 0, 0)); // c9 dup strobe
        vq.push_back(mk(0, 1, 1, 6'o23, 6'o12, 0, 0,  1, 6'o12, 1, 0, 0, 0, 0, 0, 0, 0, 0)); // c10 both, turn1
        vq.push_back(mk(0, 0, 0, 6'o23, 6'o12, 0, 0,  0, 6'o12, 1, 1, 0, 0, 0, 0, 0, 0, 0)); // c11
        vq.push_back(mk(0, 0, 0, 6'o23, 6'o12, 0, 0,  0, 6'o12, 1, 1, 0, 0, 0, 0, 0, 0, 0)); // c12
        vq.push_back(mk(0, 0, 0, 6'o23, 6'o12, 0, 0,  0, 6'o12, 1, 1, 0, 1, 0, 0, 0, 0, 0)); // c13 miss
        vq.push_back(mk(0, 1, 1, 6'o01, 6'o77, 0, 0,  1, 6'o01, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // c14 both, turn0
        vq.push_back(mk(0, 0, 0, 6'o01, 6'o77, 0, 0,  0, 6'o01, 0, 1, 0, 0, 0, 0, 0, 0, 0)); // c15
        vq.push_back(mk(0, 0, 0, 6'o01, 6'o77, 1, 0,  0, 6'o01, 0, 1, 0, 0, 0, 0, 0, 0, 0)); // c16 hit
        vq.push_back(mk(0, 0, 0, 6'o01, 6'o77, 0, 0,  0, 6'o01, 0, 1, 1, 0, 0, 0, 0, 0, 0)); // c17 hit strobe
        vq.push_back(mk(0, 0, 1, 6'o01, 6'o33, 0, 0,  1, 6'o33, 1, 0, 0, 0, 0, 1, 0, 0, 0)); // c18
        vq.push_back(mk(0, 0, 0, 6'o01, 6'o33, 0, 0,  0, 6'o33, 1, 1, 0, 0, 0, 1, 0, 0, 0)); // c19
        vq.push_back(mk(0, 0, 0, 6'o01, 6'o33, 0, 0,  0, 6'o33, 1, 1, 0, 0, 0, 1, 0, 0, 0)); // c20
        vq.push_back(mk(0, 0, 0, 6'o01, 6'o33, 0, 0,  0, 6'o33, 1, 1, 0, 1, 0, 1, 0, 0, 0)); // c21 miss
        vq.push_back(mk(0, 1, 0, 6'o02, 6'o33, 0, 0,  1, 6'o02, 0, 0, 0, 0, 0, 1, 0, 0, 0)); // c22
        vq.push_back(mk(0, 0, 0, 6'o02, 6'o33, 0, 0,  0, 6'o02, 0, 1, 0, 0, 0, 1, 0, 0, 0)); // c23
        vq.push_back(mk(0, 0, 0, 6'o02, 6'o33, 1, 0,  0, 6'o02, 0, 1, 0, 0, 0, 1, 0, 0, 0)); // c24
        vq.push_back(mk(0, 0, 0, 6'o02, 6'o33, 0, 0,  0, 6'o02, 0, 1, 1, 0, 0, 1, 0, 0, 0)); // c25 hit
        vq.push_back(mk(0, 0, 1, 6'o02, 6'o33, 0, 0,  1, 6'o33, 1, 0, 0, 0, 0, 2, 0, 0, 0)); // c26
        vq.push_back(mk(0, 0, 0, 6'o02, 6'o33, 0, 0,  0, 6'o33, 1, 1, 0, 0, 0, 2, 0, 0, 0)); // c27
        vq.push_back(mk(0, 0, 0, 6'o02, 6'o33, 0, 0,  0, 6'o33, 1, 1, 0, 0, 0, 2, 0, 0, 0)); // c28
        vq.push_back(mk(0, 0, 0, 6'o02, 6'o33, 0, 0,  0, 6'o33, 1, 1, 0, 1, 0, 2, 0, 0, 0)); // c29 miss
        vq.push_back(mk(0, 1, 0, 6'o03, 6'o33, 0, 0,  1, 6'o03, 0, 0, 0, 0, 0, 2, 0, 0, 0)); // c30
        vq.push_back(mk(0, 0, 0, 6'o03, 6'o33, 0, 0,  0, 6'o03, 0, 1, 0, 0, 0, 2, 0, 0, 0)); // c31
        vq.push_back(mk(0, 0, 0, 6'o03, 6'o33, 1, 0,  0, 6'o03, 0, 1, 0, 0, 0, 2, 0, 0, 0)); // c32
        vq.push_back(mk(0, 0, 0, 6'o03, 6'o33, 0, 0,  0, 6'o03, 0, 1, 1, 0, 0, 2, 0, 0, 0)); // c33 winning hit
        vq.push_back(mk(0, 1, 0, 6'o03, 6'o33, 0, 0,  0, 6'o03, 0, 0, 0, 0, 0, 3, 0, 1, 0)); // c34 DONE, fire0 ignored
        vq.push_back(mk(0, 0, 1, 6'o03, 6'o33, 0, 0,  0, 6'o03, 0, 0, 0, 0, 0, 3, 0, 1, 0)); // c35 fire1 ignored
        vq.push_back(mk(1, 0, 0, 6'o03, 6'o33, 0, 0,  0, 6'o03, 0, 0, 0, 0, 0, 3, 0, 1, 0)); // c36 new_game in DONE
        vq.push_back(mk(0, 1, 0, 6'o04, 6'o33, 0, 0,  1, 6'o04, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // c37 cleared
        vq.push_back(mk(0, 0, 0, 6'o04, 6'o33, 0, 0,  0, 6'o04, 0, 1, 0, 0, 0, 0, 0, 0, 0)); // c38
        vq.push_back(mk(0, 0, 0, 6'o04, 6'o33, 1, 0,  0, 6'o04, 0, 1, 0, 0, 0, 0, 0, 0, 0)); // c39 hit
        vq.push_back(mk(1, 0, 0, 6'o04, 6'o33, 0, 0,  0, 6'o04, 0, 1, 0, 0, 0, 0, 0, 0, 0)); // c40 new_game in RESULT
        vq.push_back(mk(1, 1, 0, 6'o04, 6'o33, 0, 0,  0, 6'o04, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // c41 new_game beats fire
        vq.push_back(mk(0, 1, 0, 6'o05, 6'o33, 0, 0,  1, 6'o05, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // c42
        vq.push_back(mk(0, 0, 0, 6'o05, 6'o33, 0, 0,  0, 6'o05, 0, 1, 0, 0, 0, 0, 0, 0, 0)); // c43
        vq.push_back(mk(0, 0, 0, 6'o05, 6'o33, 0, 0,  0, 6'o05, 0, 1, 0, 0, 0, 0, 0, 0, 0)); // c44
        vq.push_back(mk(0, 0, 0, 6'o05, 6'o33, 0, 0,  0, 6'o05, 0, 1, 0, 1, 0, 0, 0, 0, 0)); // c45 miss

        // Reset state while clr is held, with fire0 high.
        #2;
        check("reset_outs", 32'(outs()), 32'({1'b0, 6'o23, 1'b0, 1'b0, 3'b000, SW'(0), SW'(0), 1'b0, 1'b0}));
        #10 clr = 1'b1;
        fire0 = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < vq.size(); i++) begin
            new_game = vq[i].ng; fire0 = vq[i].f0; fire1 = vq[i].f1;
            coord0 = vq[i].c0; coord1 = vq[i].c1;
            lkp_hit = vq[i].h; lkp_dup = vq[i].d;
            @(negedge clk);
            check($sformatf("vec%0d", i), 32'(outs()), 32'(vq[i].exp));
            @(posedge clk); #1;
        end

        // Asynchronous reset in the middle of a player-1 lookup.
        new_game = 1'b0; fire0 = 1'b0; fire1 = 1'b1; lkp_hit = 1'b0; lkp_dup = 1'b0;
        coord1 = 6'o66;
        @(negedge clk);
        check("p1_turn", 32'(turn), 32'd1);
        check("p1_load", 32'({reg_en, reg_d}), 32'({1'b1, 6'o66}));
        @(posedge clk); #1;
        fire1 = 1'b0;
        lkp_hit = 1'b1;
        @(negedge clk);
        check("lookup_busy", 32'(busy), 32'd1);
        #1 clr = 1'b0;
        #1;
        check("async_outs", 32'(outs()), 32'({1'b0, 6'o05, 1'b0, 1'b0, 3'b000, SW'(0), SW'(0), 1'b0, 1'b0}));
        #2 clr = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check($sformatf("abort_quiet%0d", i),
                  32'({busy, hit_pulse, miss_pulse, dup_pulse, turn, score0, score1}), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Overall time guard so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
